// File: rtl/wshb_arbiter2.sv
// Two-master Wishbone arbiter in front of a single SDRAM slave port, with a starvation pulse.
// Define WSHB_ARB_RR_EN for round-robin ties; the default build gives master 0 fixed priority.
//   state | meaning
//   IDLE  | no owner, slave outputs forced to 0
//   OWN0  | master 0 (video reader) owns the slave
//   OWN1  | master 1 (pixel writer) owns the slave
module wshb_arbiter2 #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_HOLD = 1024
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  input  logic            m0_we_i,
  input  logic [AW-1:0]   m0_adr_i,
  input  logic [DW-1:0]   m0_dat_w_i,
  input  logic [DW/8-1:0] m0_sel_i,
  output logic            m0_ack_o,
  output logic [DW-1:0]   m0_dat_r_o,
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  input  logic            m1_we_i,
  input  logic [AW-1:0]   m1_adr_i,
  input  logic [DW-1:0]   m1_dat_w_i,
  input  logic [DW/8-1:0] m1_sel_i,
  output logic            m1_ack_o,
  output logic [DW-1:0]   m1_dat_r_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  output logic            s_we_o,
  output logic [AW-1:0]   s_adr_o,
  output logic [DW-1:0]   s_dat_w_o,
  output logic [DW/8-1:0] s_sel_o,
  input  logic            s_ack_i,
  input  logic [DW-1:0]   s_dat_r_i,
  output logic [1:0]      gnt_o,
  output logic            starve_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  localparam logic [15:0] HOLD_MAX = 16'(MAX_HOLD);

  state_t      state_q, state_d;
  logic [15:0] hold_q, hold_d;
  logic        starve_q, starve_d;
  logic [1:0]  gnt_q, gnt_d;
  logic        other_wait;
  state_t      tie_winner;

`ifdef WSHB_ARB_RR_EN
  logic last_q, last_d;

  // last remembers the most recent owner so a tie goes to the other master
  always_comb begin
    last_d = last_q;
    if (state_d == OWN0 && state_q != OWN0) last_d = 1'b0;
    if (state_d == OWN1 && state_q != OWN1) last_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) last_q <= 1'b1;
    else       last_q <= last_d;
  end

  assign tie_winner = last_q ? OWN0 : OWN1;
`else
  assign tie_winner = OWN0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) state_d = tie_winner;
        else if (m0_cyc_i)        state_d = OWN0;
        else if (m1_cyc_i)        state_d = OWN1;
      end
      OWN0: if (!m0_cyc_i) state_d = m1_cyc_i ? OWN1 : IDLE;
      OWN1: if (!m1_cyc_i) state_d = m0_cyc_i ? OWN0 : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Hold counter only runs while the current owner keeps the other master waiting
  always_comb begin
    other_wait = (state_q == OWN0 && m1_cyc_i) || (state_q == OWN1 && m0_cyc_i);
    hold_d     = hold_q;
    if (state_d != state_q || state_q == IDLE) hold_d = 16'd0;
    else if (other_wait && hold_q != HOLD_MAX) hold_d = hold_q + 16'd1;
    starve_d = (hold_d == HOLD_MAX) && (hold_q != HOLD_MAX);
    gnt_d    = {state_d == OWN1, state_d == OWN0};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      hold_q   <= 16'd0;
      starve_q <= 1'b0;
      gnt_q    <= 2'b00;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      starve_q <= starve_d;
      gnt_q    <= gnt_d;
    end
  end

  always_comb begin
    s_cyc_o   = 1'b0;
    s_stb_o   = 1'b0;
    s_we_o    = 1'b0;
    s_adr_o   = '0;
    s_dat_w_o = '0;
    s_sel_o   = '0;
    m0_ack_o  = 1'b0;
    m1_ack_o  = 1'b0;
    case (state_q)
      OWN0: begin
        s_cyc_o   = m0_cyc_i;
        s_stb_o   = m0_stb_i & m0_cyc_i;
        s_we_o    = m0_we_i;
        s_adr_o   = m0_adr_i;
        s_dat_w_o = m0_dat_w_i;
        s_sel_o   = m0_sel_i;
        m0_ack_o  = s_ack_i;
      end
      OWN1: begin
        s_cyc_o   = m1_cyc_i;
        s_stb_o   = m1_stb_i & m1_cyc_i;
        s_we_o    = m1_we_i;
        s_adr_o   = m1_adr_i;
        s_dat_w_o = m1_dat_w_i;
        s_sel_o   = m1_sel_i;
        m1_ack_o  = s_ack_i;
      end
      default: ;
    endcase
  end

  assign m0_dat_r_o = s_dat_r_i;
  assign m1_dat_r_o = s_dat_r_i;
  assign gnt_o      = gnt_q;
  assign starve_o   = starve_q;

endmodule

// File: tb/tb_wshb_arbiter2.sv
// Directed bench for wshb_arbiter2 with MAX_HOLD=8; expected values are hand-derived.
module tb_wshb_arbiter2;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        m0_cyc_i, m0_stb_i, m0_we_i;
  logic [31:0] m0_adr_i, m0_dat_w_i;
  logic [3:0]  m0_sel_i;
  logic        m0_ack_o;
  logic [31:0] m0_dat_r_o;
  logic        m1_cyc_i, m1_stb_i, m1_we_i;
  logic [31:0] m1_adr_i, m1_dat_w_i;
  logic [3:0]  m1_sel_i;
  logic        m1_ack_o;
  logic [31:0] m1_dat_r_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [31:0] s_adr_o, s_dat_w_o;
  logic [3:0]  s_sel_o;
  logic        s_ack_i;
  logic [31:0] s_dat_r_i;
  logic [1:0]  gnt_o;
  logic        starve_o;

  int checks   = 0;
  int failures = 0;

  wshb_arbiter2 #(.AW(32), .DW(32), .MAX_HOLD(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
    .m0_adr_i(m0_adr_i), .m0_dat_w_i(m0_dat_w_i), .m0_sel_i(m0_sel_i),
    .m0_ack_o(m0_ack_o), .m0_dat_r_o(m0_dat_r_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
    .m1_adr_i(m1_adr_i), .m1_dat_w_i(m1_dat_w_i), .m1_sel_i(m1_sel_i),
    .m1_ack_o(m1_ack_o), .m1_dat_r_o(m1_dat_r_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_adr_o(s_adr_o), .s_dat_w_o(s_dat_w_o), .s_sel_o(s_sel_o),
    .s_ack_i(s_ack_i), .s_dat_r_i(s_dat_r_i),
    .gnt_o(gnt_o), .starve_o(starve_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  logic [1:0] tie_exp [4];
  int starve_cnt, starve_at, gnt_bad;

  initial begin
    rst_i = 1'b1; s_ack_i = 1'b1; s_dat_r_i = 32'h0;
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_we_i = 1'b0;
    m0_adr_i = 32'h0; m0_dat_w_i = 32'h0; m0_sel_i = 4'h0;
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_we_i = 1'b0;
    m1_adr_i = 32'h0; m1_dat_w_i = 32'h0; m1_sel_i = 4'h0;

    // reset held for 3 cycles with both masters requesting
    repeat (3) step();
    #1;
    chk("rst_gnt", 32'(gnt_o), 32'h0);
    chk("rst_s_cyc", 32'(s_cyc_o), 32'h0);
    chk("rst_s_adr", s_adr_o, 32'h0);
    chk("rst_m0_ack", 32'(m0_ack_o), 32'h0);
    chk("rst_m1_ack", 32'(m1_ack_o), 32'h0);
    chk("rst_starve", 32'(starve_o), 32'h0);
    rst_i = 1'b0; s_ack_i = 1'b0;
    step();
    chk("post_rst_gnt", 32'(gnt_o), 32'h1);
    chk("post_rst_s_cyc", 32'(s_cyc_o), 32'h1);
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
    step();
    chk("idle_gnt", 32'(gnt_o), 32'h0);

    // single master 1 write, slave acks 2 cycles after grant
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_we_i = 1'b1;
    m1_adr_i = 32'h100; m1_dat_w_i = 32'hCAFE0001; m1_sel_i = 4'hF;
    step();
    chk("wr_gnt", 32'(gnt_o), 32'h2);
    chk("wr_s_adr", s_adr_o, 32'h100);
    chk("wr_s_we", 32'(s_we_o), 32'h1);
    chk("wr_s_stb", 32'(s_stb_o), 32'h1);
    chk("wr_s_dat", s_dat_w_o, 32'hCAFE0001);
    chk("wr_s_sel", 32'(s_sel_o), 32'hF);
    chk("wr_ack_early", 32'(m1_ack_o), 32'h0);
    step();
    chk("wr_ack_early2", 32'(m1_ack_o), 32'h0);
    step();
    s_ack_i = 1'b1; s_dat_r_i = 32'h12345678;
    #1;
    chk("wr_m1_ack", 32'(m1_ack_o), 32'h1);
    chk("wr_m0_ack", 32'(m0_ack_o), 32'h0);
    chk("wr_m1_dat_r", m1_dat_r_o, 32'h12345678);
    chk("wr_m0_dat_r", m0_dat_r_o, 32'h12345678);
    step();
    s_ack_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0; m1_we_i = 1'b0;
    #1;
    chk("wr_ack_once", 32'(m1_ack_o), 32'h0);
    step();
    chk("wr_idle_gnt", 32'(gnt_o), 32'h0);
    chk("wr_idle_s_adr", s_adr_o, 32'h0);

    // ties from IDLE; round-robin alternates starting from master 0 since last owner was 1
`ifdef WSHB_ARB_RR_EN
    tie_exp[0] = 2'b01; tie_exp[1] = 2'b10; tie_exp[2] = 2'b01; tie_exp[3] = 2'b10;
`else
    tie_exp[0] = 2'b01; tie_exp[1] = 2'b01; tie_exp[2] = 2'b01; tie_exp[3] = 2'b01;
`endif
    for (int n = 0; n < 4; n++) begin
      m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
      step();
      chk($sformatf("tie%0d_gnt", n), 32'(gnt_o), 32'(tie_exp[n]));
      m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
      step();
      chk($sformatf("tie%0d_idle", n), 32'(gnt_o), 32'h0);
    end

    // 16-beat master 0 burst with master 1 waiting, then handover without idle
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_we_i = 1'b0; m0_adr_i = 32'h1000;
    step();
    chk("ho_gnt0", 32'(gnt_o), 32'h1);
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_we_i = 1'b1; m1_adr_i = 32'h200;
    for (int b = 0; b < 16; b++) begin
      m0_adr_i = 32'h1000 + 32'(b * 4); s_ack_i = 1'b1;
      #1;
      if (b == 0 || b == 15) begin
        chk($sformatf("ho_beat%0d_adr", b), s_adr_o, 32'h1000 + 32'(b * 4));
        chk($sformatf("ho_beat%0d_ack", b), 32'(m0_ack_o), 32'h1);
        chk($sformatf("ho_beat%0d_m1ack", b), 32'(m1_ack_o), 32'h0);
      end
      step();
    end
    s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    #1;
    chk("ho_drop_gnt", 32'(gnt_o), 32'h1);
    step();
    chk("ho_gnt1", 32'(gnt_o), 32'h2);
    chk("ho_s_adr", s_adr_o, 32'h200);
    chk("ho_s_cyc", 32'(s_cyc_o), 32'h1);
    chk("ho_s_we", 32'(s_we_o), 32'h1);
    m1_cyc_i = 1'b0; m1_stb_i = 1'b0; m1_we_i = 1'b0;
    step();
    chk("ho_idle", 32'(gnt_o), 32'h0);

    // starvation: master 0 holds 20 cycles, master 1 waits; pulse expected in waiting cycle 9
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 32'h2000;
    step();
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_adr_i = 32'h300;
    starve_cnt = 0; starve_at = 0; gnt_bad = 0;
    for (int j = 1; j <= 20; j++) begin
      #1;
      if (starve_o) begin
        starve_cnt++;
        starve_at = j;
      end
      if (gnt_o != 2'b01) gnt_bad++;
      step();
    end
    chk("starve_count", 32'(starve_cnt), 32'd1);
    chk("starve_cycle", 32'(starve_at), 32'd9);
    chk("starve_gnt_held", 32'(gnt_bad), 32'd0);
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    step();
    chk("starve_ho_gnt", 32'(gnt_o), 32'h2);
    chk("starve_ho_pulse", 32'(starve_o), 32'h0);
    m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
    step();

    // reset mid-read with the slave ack arriving in the same cycle
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_we_i = 1'b0; m0_adr_i = 32'h400;
    step();
    chk("mrd_gnt", 32'(gnt_o), 32'h1);
    s_ack_i = 1'b1; s_dat_r_i = 32'hDEAD0000; rst_i = 1'b1;
    step();
    chk("mrd_s_cyc", 32'(s_cyc_o), 32'h0);
    chk("mrd_m0_ack", 32'(m0_ack_o), 32'h0);
    chk("mrd_gnt_idle", 32'(gnt_o), 32'h0);
    rst_i = 1'b0; s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
